// File: rtl/wb_uart_rx_fifo_if.sv
// Wishbone slave bundle for wb_uart_rx_fifo.
// Purpose: groups the Wishbone handshake and data signals so the CPU side
// (master) and the UART receiver (slave) share one connection object.
// Signals:
//   wb_adr_i  [31:0] byte address, only [3:2] decoded by the slave
//   wb_dat_i  [31:0] write data from the master
//   wb_dat_o  [31:0] read data, valid while wb_ack_o is high
//   wb_stb_i, wb_cyc_i, wb_we_i  strobe, cycle, write enable
//   wb_sel_i  [3:0]  byte lanes, ignored by the slave
//   wb_ack_o         one-cycle acknowledge
interface wb_uart_rx_fifo_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_uart_rx_fifo.sv
// wb_uart_rx_fifo
// Purpose: receives 8N1 serial bytes on uart_rxd, buffers them in a FIFO and
// lets the CPU drain them through four memory-mapped Wishbone registers:
//   0x0 DATA    read pops the head byte as {23'b0, 1'b1, byte}, 0 when empty
//   0x4 STATUS  [8:0] count, [16] empty, [17] full, [18] overrun, [19] frame_err
//               write 1 to bit 18/19 clears that sticky flag
//   0x8 CTRL    [0] rx_en, [1] irq_en, [16:8] threshold (0 behaves as 1)
//   0xC DIVISOR [15:0] clocks per bit, minimum 16
// Ports:
//   clk, reset  single clock, synchronous active-high reset
//   wb          Wishbone slave bundle (wb_uart_rx_fifo_if.slave)
//   uart_rxd    asynchronous serial input, idle high
//   intr        registered active-high interrupt request
module wb_uart_rx_fifo #(
  parameter int clk_freq   = 100000000,
  parameter int baud       = 115200,
  parameter int fifo_depth = 16
) (
  input  logic              clk,
  input  logic              reset,
  wb_uart_rx_fifo_if.slave  wb,
  input  logic              uart_rxd,
  output logic              intr
);

  localparam int AW = $clog2(fifo_depth);
  localparam int CW = AW + 1;
  localparam logic [15:0] RESET_DIV = 16'(clk_freq / baud);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rxState_t;

  logic           ack_q, ack_d;
  logic [31:0]    dat_q, dat_d;
  logic           intr_q, intr_d;
  logic           rxdMeta_q, rxdSync_q;
  rxState_t       state_q, state_d;
  logic [15:0]    timer_q, timer_d;
  logic [15:0]    frameDiv_q, frameDiv_d;
  logic [2:0]     bitIdx_q, bitIdx_d;
  logic [7:0]     shift_q, shift_d;
  logic           rxEn_q, rxEn_d;
  logic           irqEn_q, irqEn_d;
  logic [8:0]     thr_q, thr_d;
  logic [15:0]    divisor_q, divisor_d;
  logic           overrun_q, overrun_d;
  logic           frameErr_q, frameErr_d;
  logic [AW-1:0]  wrPtr_q, wrPtr_d;
  logic [AW-1:0]  rdPtr_q, rdPtr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     mem_q [fifo_depth];

  logic           accept, isRead;
  logic [1:0]     regSel;
  logic           wrStatus, wrCtrl, wrDiv;
  logic           fifoEmpty, fifoFull;
  logic           pop, doPush, ovSet;
  logic           rxPush, rxFrameErr, tick;
  logic [8:0]     thrEff;
  logic [31:0]    rdMux;
  logic           unusedBits;

  // A new access is accepted only while no ack is pending, which spaces
  // accesses so every request receives exactly one single-cycle ack.
  assign accept   = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign isRead   = accept & ~wb.wb_we_i;
  assign regSel   = wb.wb_adr_i[3:2];
  assign wrStatus = accept & wb.wb_we_i & (regSel == 2'd1);
  assign wrCtrl   = accept & wb.wb_we_i & (regSel == 2'd2);
  assign wrDiv    = accept & wb.wb_we_i & (regSel == 2'd3);

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CW'(fifo_depth));
  assign pop       = isRead & (regSel == 2'd0) & ~fifoEmpty;
  assign doPush    = rxPush & (~fifoFull | pop);
  assign ovSet     = rxPush & fifoFull & ~pop;
  assign thrEff    = (thr_q == 9'd0) ? 9'd1 : thr_q;
  assign tick      = (timer_q == 16'd1);

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign intr        = intr_q;

  assign unusedBits = &{1'b0, wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                        wb.wb_dat_i[31:20]};

  // Register read multiplexer; the value is captured alongside ack so the
  // master sees the state as it was when the access was accepted.
  always_comb begin
    rdMux = '0;
    case (regSel)
      2'd0: rdMux = fifoEmpty ? 32'd0 : {23'd0, 1'b1, mem_q[rdPtr_q]};
      2'd1: rdMux = {12'd0, frameErr_q, overrun_q, fifoFull, fifoEmpty,
                     7'd0, 9'(count_q)};
      2'd2: rdMux = {15'd0, thr_q, 6'd0, irqEn_q, rxEn_q};
      default: rdMux = {16'd0, divisor_q};
    endcase
  end

  // Receive FSM. The bit timer is loaded with a number of clocks and "tick"
  // marks the clock in which it reaches zero, so a load of DIVISOR spaces
  // samples exactly DIVISOR clocks apart. The divisor is latched per frame
  // so a register write cannot disturb a frame already in flight.
  always_comb begin
    state_d    = state_q;
    timer_d    = (timer_q != 16'd0) ? timer_q - 16'd1 : 16'd0;
    frameDiv_d = frameDiv_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    rxPush     = 1'b0;
    rxFrameErr = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rxdSync_q) begin
          frameDiv_d = divisor_q;
          timer_d    = divisor_q >> 1;
          state_d    = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (!rxdSync_q) begin
            timer_d  = frameDiv_q;
            bitIdx_d = 3'd0;
            state_d  = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          shift_d = {rxdSync_q, shift_q[7:1]};
          timer_d = frameDiv_q;
          if (bitIdx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rxdSync_q) begin
            rxPush  = 1'b1;
            state_d = RX_IDLE;
          end else begin
            rxFrameErr = 1'b1;
            state_d    = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (rxdSync_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    if (!rxEn_q) begin
      state_d    = RX_IDLE;
      timer_d    = 16'd0;
      rxPush     = 1'b0;
      rxFrameErr = 1'b0;
    end
  end

  // Next state of the control registers, FIFO pointers, sticky flags, the
  // bus response and the interrupt line. Flag sets win over a clear that
  // lands in the same cycle so no event is ever silently lost.
  always_comb begin
    rxEn_d     = rxEn_q;
    irqEn_d    = irqEn_q;
    thr_d      = thr_q;
    divisor_d  = divisor_q;
    if (wrCtrl) begin
      rxEn_d  = wb.wb_dat_i[0];
      irqEn_d = wb.wb_dat_i[1];
      thr_d   = wb.wb_dat_i[16:8];
    end
    if (wrDiv) begin
      divisor_d = (wb.wb_dat_i[15:0] < 16'd16) ? 16'd16 : wb.wb_dat_i[15:0];
    end
    overrun_d  = ovSet | (overrun_q & ~(wrStatus & wb.wb_dat_i[18]));
    frameErr_d = rxFrameErr | (frameErr_q & ~(wrStatus & wb.wb_dat_i[19]));
    wrPtr_d    = wrPtr_q + AW'(doPush);
    rdPtr_d    = rdPtr_q + AW'(pop);
    count_d    = count_q + CW'(doPush) - CW'(pop);
    ack_d      = accept;
    dat_d      = isRead ? rdMux : 32'd0;
    intr_d     = irqEn_q & ((9'(count_q) >= thrEff) | overrun_q | frameErr_q);
  end

  // State registers with synchronous reset; the synchroniser idles high so
  // reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
      intr_q     <= 1'b0;
      rxdMeta_q  <= 1'b1;
      rxdSync_q  <= 1'b1;
      state_q    <= RX_IDLE;
      timer_q    <= 16'd0;
      frameDiv_q <= RESET_DIV;
      bitIdx_q   <= 3'd0;
      shift_q    <= 8'd0;
      rxEn_q     <= 1'b0;
      irqEn_q    <= 1'b0;
      thr_q      <= 9'd0;
      divisor_q  <= RESET_DIV;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      intr_q     <= intr_d;
      rxdMeta_q  <= uart_rxd;
      rxdSync_q  <= rxdMeta_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      frameDiv_q <= frameDiv_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      rxEn_q     <= rxEn_d;
      irqEn_q    <= irqEn_d;
      thr_q      <= thr_d;
      divisor_q  <= divisor_d;
      overrun_q  <= overrun_d;
      frameErr_q <= frameErr_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= shift_q;
    end
  end

endmodule

// File: tb/tb_wb_uart_rx_fifo.sv
// Testbench for wb_uart_rx_fifo.
// Purpose: drives 8N1 frames and Wishbone accesses, predicts register
// contents from a byte-queue model of the receiver and checks every bus
// response through a scoreboard popped by an independent monitor.
module tb_wb_uart_rx_fifo;

  localparam int DEPTH = 16;

  typedef struct {
    bit          isRead;
    logic [31:0] exp;
    string       name;
  } sbEntry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uartRxd = 1'b1;
  logic intr;

  int checks = 0;
  int failures = 0;
  int tbDiv = 16;
  bit prevAck = 1'b0;

  sbEntry_t   expQ[$];
  logic [7:0] modelQ[$];
  bit         modelOv = 1'b0;
  bit         modelFe = 1'b0;
  bit         modelRxEn = 1'b0;
  bit         modelIrqEn = 1'b0;
  int         modelThr = 0;

  wb_uart_rx_fifo_if wbIf ();

  wb_uart_rx_fifo #(
    .clk_freq  (100000000),
    .baud      (115200),
    .fifo_depth(DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wb      (wbIf),
    .uart_rxd(uartRxd),
    .intr    (intr)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case a wait is never satisfied.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one scoreboard entry; reads are compared, ack
  // width and the idle data bus are checked as well.
  always @(negedge clk) begin
    sbEntry_t e;
    if (wbIf.wb_ack_o === 1'b1) begin
      checkOutput("ackWidth", {31'd0, prevAck}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpectedAck", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        if (e.isRead) checkOutput(e.name, wbIf.wb_dat_o, e.exp);
      end
    end else if (prevAck) begin
      checkOutput("datIdle", wbIf.wb_dat_o, 32'd0);
    end
    prevAck = (wbIf.wb_ack_o === 1'b1);
  end

  function automatic logic [31:0] expStatus();
    logic [31:0] s;
    s = 32'd0;
    s[8:0] = 9'(modelQ.size());
    s[16] = (modelQ.size() == 0);
    s[17] = (modelQ.size() == DEPTH);
    s[18] = modelOv;
    s[19] = modelFe;
    return s;
  endfunction

  function automatic logic [31:0] popExpected();
    if (modelQ.size() == 0) return 32'd0;
    return {23'd0, 1'b1, modelQ.pop_front()};
  endfunction

  function automatic logic expIntr();
    int thr;
    thr = (modelThr == 0) ? 1 : modelThr;
    return modelIrqEn && ((modelQ.size() >= thr) || modelOv || modelFe);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wbAccess(input bit we, input logic [3:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp,
                          input string name);
    bit got;
    sbEntry_t e;
    e.isRead = ~we;
    e.exp = exp;
    e.name = name;
    expQ.push_back(e);
    @(negedge clk);
    wbIf.wb_adr_i = {28'd0, addr};
    wbIf.wb_dat_i = wdata;
    wbIf.wb_we_i  = we;
    wbIf.wb_stb_i = 1'b1;
    wbIf.wb_cyc_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (wbIf.wb_ack_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput({name, "Timeout"}, 32'd0, 32'd1);
    wbIf.wb_stb_i = 1'b0;
    wbIf.wb_cyc_i = 1'b0;
    wbIf.wb_we_i  = 1'b0;
  endtask

  task automatic wbRead(input logic [3:0] addr, input logic [31:0] exp,
                        input string name);
    wbAccess(1'b0, addr, 32'd0, exp, name);
  endtask

  task automatic wbWrite(input logic [3:0] addr, input logic [31:0] data);
    wbAccess(1'b1, addr, data, 32'd0, "write");
    if (addr == 4'h8) begin
      modelRxEn  = data[0];
      modelIrqEn = data[1];
      modelThr   = int'(data[16:8]);
    end
    if (addr == 4'h4) begin
      if (data[18]) modelOv = 1'b0;
      if (data[19]) modelFe = 1'b0;
    end
  endtask

  // Sends one 8N1 frame and updates the model with its outcome.
  task automatic applyStimulus(input logic [7:0] b, input bit goodStop);
    @(negedge clk);
    uartRxd = 1'b0;
    repeat (tbDiv) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uartRxd = b[i];
      repeat (tbDiv) @(negedge clk);
    end
    uartRxd = goodStop;
    repeat (tbDiv) @(negedge clk);
    if (modelRxEn) begin
      if (!goodStop) modelFe = 1'b1;
      else if (modelQ.size() < DEPTH) modelQ.push_back(b);
      else modelOv = 1'b1;
    end
  endtask

  // Start bit plus a few data bits, leaving the line low mid-frame.
  task automatic partialFrame(input int nBits);
    @(negedge clk);
    uartRxd = 1'b0;
    repeat (tbDiv * (nBits + 1)) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    modelQ.delete();
    modelOv = 1'b0;
    modelFe = 1'b0;
    modelRxEn = 1'b0;
    modelIrqEn = 1'b0;
    modelThr = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = modelQ.size();
    for (int i = 0; i <= n; i++) wbRead(4'h0, popExpected(), name);
  endtask

  initial begin
    int n;
    wbIf.wb_adr_i = 32'd0;
    wbIf.wb_dat_i = 32'd0;
    wbIf.wb_stb_i = 1'b0;
    wbIf.wb_cyc_i = 1'b0;
    wbIf.wb_we_i  = 1'b0;
    wbIf.wb_sel_i = 4'hF;
    doReset();

    // Reset values of every register.
    wbRead(4'h0, 32'd0, "rstData");
    wbRead(4'h4, 32'h0001_0000, "rstStatus");
    wbRead(4'h8, 32'd0, "rstCtrl");
    wbRead(4'hC, 32'd868, "rstDivisor");
    checkOutput("rstIntr", {31'd0, intr}, 32'd0);

    // Divisor floor, then the working configuration.
    wbWrite(4'hC, 32'd5);
    wbRead(4'hC, 32'd16, "divFloor");
    wbWrite(4'hC, 32'd16);
    wbRead(4'hC, 32'd16, "divSet");
    wbWrite(4'h8, 32'd1);
    wbRead(4'h8, 32'd1, "ctrlSet");

    // Two known bytes.
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    idle(4);
    wbRead(4'h4, expStatus(), "status2");
    drain("data2");

    // Random bursts with random gaps.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        applyStimulus(8'($urandom), 1'b1);
        idle($urandom_range(0, 20));
      end
      idle(4);
      wbRead(4'h4, expStatus(), "statusRand");
      drain("dataRand");
    end

    // Overflow: 17 bytes into a 16-deep FIFO.
    for (int k = 0; k < DEPTH + 1; k++) applyStimulus(8'($urandom), 1'b1);
    idle(4);
    wbRead(4'h4, expStatus(), "statusFull");
    wbWrite(4'h4, 32'h0004_0000);
    wbRead(4'h4, expStatus(), "statusOvClr");
    drain("dataFull");
    wbRead(4'h4, expStatus(), "statusDrained");

    // Framing error followed by a long break.
    applyStimulus(8'h81, 1'b0);
    repeat (100 * tbDiv) @(negedge clk);
    wbRead(4'h4, expStatus(), "statusBreak");
    uartRxd = 1'b1;
    idle(40);
    applyStimulus(8'h55, 1'b1);
    idle(4);
    wbRead(4'h0, popExpected(), "data55");
    wbWrite(4'h4, 32'h0008_0000);
    wbRead(4'h4, expStatus(), "statusFeClr");

    // Interrupt at a threshold of three.
    wbWrite(4'h8, 32'h0000_0303);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    idle(3);
    checkOutput("intrBelow", {31'd0, intr}, {31'd0, expIntr()});
    applyStimulus(8'h33, 1'b1);
    idle(3);
    checkOutput("intrAt", {31'd0, intr}, {31'd0, expIntr()});
    wbRead(4'h0, popExpected(), "dataIrq");
    idle(3);
    checkOutput("intrAfterRead", {31'd0, intr}, {31'd0, expIntr()});
    drain("dataIrqRest");

    // Threshold zero behaves as one.
    wbWrite(4'h8, 32'h0000_0003);
    idle(3);
    checkOutput("intrThr0Empty", {31'd0, intr}, {31'd0, expIntr()});
    applyStimulus(8'h44, 1'b1);
    idle(3);
    checkOutput("intrThr0One", {31'd0, intr}, {31'd0, expIntr()});
    drain("dataThr0");
    wbWrite(4'h8, 32'h0000_0001);

    // rx_en dropped mid-frame.
    applyStimulus(8'h77, 1'b1);
    partialFrame(3);
    wbWrite(4'h8, 32'd0);
    repeat (tbDiv * 5) @(negedge clk);
    uartRxd = 1'b1;
    idle(40);
    wbWrite(4'h8, 32'd1);
    wbRead(4'h4, expStatus(), "statusRxOff");
    drain("dataRxOff");

    // Short glitch is rejected by the start-bit check.
    @(negedge clk);
    uartRxd = 1'b0;
    idle(3);
    uartRxd = 1'b1;
    idle(60);
    wbRead(4'h4, expStatus(), "statusGlitch");
    applyStimulus(8'h5A, 1'b1);
    idle(4);
    wbRead(4'h0, popExpected(), "dataGlitch");

    // Reset mid-frame wipes the FIFO and registers.
    applyStimulus(8'h99, 1'b1);
    partialFrame(3);
    doReset();
    repeat (tbDiv * 5) @(negedge clk);
    uartRxd = 1'b1;
    idle(40);
    wbRead(4'h4, 32'h0001_0000, "statusRstMid");
    wbRead(4'h8, 32'd0, "ctrlRstMid");
    wbRead(4'hC, 32'd868, "divRstMid");
    wbWrite(4'hC, 32'd16);
    wbWrite(4'h8, 32'd1);
    applyStimulus(8'hC3, 1'b1);
    idle(4);
    wbRead(4'h0, popExpected(), "dataAfterRst");

    idle(5);
    checkOutput("sbDrained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
